// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: shared transmitter state encoding and default sizing for the CPU output UART
package cpu_io_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int FIFO_DEPTH = 16;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO, 2**ADDRESSWIDTH entries
//   clock/reset (async active-low), push/wdata write, pop read,
//   rdata = head entry (combinational), full/empty flags, count = occupancy
module sync_fifo #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRESSWIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATAWIDTH-1:0]  wdata,
    output logic [DATAWIDTH-1:0]  rdata,
    output logic                  full,
    output logic                  empty,
    output logic [ADDRESSWIDTH:0] count
);
    localparam int DEPTH = 1 << ADDRESSWIDTH;
    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [ADDRESSWIDTH-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (ADDRESSWIDTH+1)'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop & ~empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push & (~full | do_pop);
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (ADDRESSWIDTH+1)'(do_push) - (ADDRESSWIDTH+1)'(do_pop);
        end
    end
endmodule

// File: rtl/cpu_out_uart.sv
// cpu_out_uart: buffers CPU output bytes in a FIFO and sends them as UART 8N1
//   clock/reset (async active-low); out/outFlag/endFlag from the CPU;
//   tx serial line (idles high), busy = frame on wire, done = end seen and fully drained,
//   overflow = sticky byte-dropped flag, count = FIFO occupancy
module cpu_out_uart
    import cpu_io_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int ADDRESSWIDTH = 4,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATAWIDTH-1:0]  out,
    input  logic                  outFlag,
    input  logic                  endFlag,
    output logic                  tx,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDRESSWIDTH:0] count
);
    localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = DATAWIDTH > 1 ? $clog2(DATAWIDTH) : 1;
    uart_state_t state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [IW-1:0] bit_idx, bit_n;
    logic [DATAWIDTH-1:0] shift, shift_n, rdata;
    logic tx_n, pop, push, flag_prev, end_seen, full, empty, baud_end;
    // one byte per rising edge of the strobe, however long it is held
    assign push = outFlag & ~flag_prev;
    assign busy = state != IDLE;
    assign baud_end = baud == BW'(CLKS_PER_BIT - 1);
    sync_fifo #(.DATAWIDTH(DATAWIDTH), .ADDRESSWIDTH($clog2(DEPTH))) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .wdata(out),
        .rdata(rdata),
        .full(full),
        .empty(empty),
        .count(count)
    );
    always_comb begin
        state_n = state;
        baud_n = baud;
        bit_n = bit_idx;
        shift_n = shift;
        pop = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop = 1'b1;
                shift_n = rdata;
                baud_n = '0;
                state_n = START;
            end
            START: if (baud_end) begin
                baud_n = '0;
                bit_n = '0;
                state_n = DATA;
            end else baud_n = baud + 1'b1;
            DATA: if (baud_end) begin
                baud_n = '0;
                shift_n = shift >> 1;
                bit_n = bit_idx + 1'b1;
                if (bit_idx == IW'(DATAWIDTH - 1)) state_n = STOP;
            end else baud_n = baud + 1'b1;
            STOP: if (baud_end) begin
                baud_n = '0;
                state_n = IDLE;
            end else baud_n = baud + 1'b1;
            default: state_n = IDLE;
        endcase
        // tx register follows the state being entered, so the line changes with the state
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            baud <= '0;
            bit_idx <= '0;
            shift <= '0;
            tx <= 1'b1;
            flag_prev <= 1'b0;
            end_seen <= 1'b0;
            done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            baud <= baud_n;
            bit_idx <= bit_n;
            shift <= shift_n;
            tx <= tx_n;
            flag_prev <= outFlag;
            end_seen <= end_seen | endFlag;
            done <= end_seen & empty & (state == IDLE);
            overflow <= overflow | (push & full & ~pop);
        end
    end
endmodule

// File: tb/tb_cpu_out_uart.sv
// tb_cpu_out_uart: scoreboard bench; stimulus queues expected bytes, a UART monitor decodes tx and compares
module tb_cpu_out_uart;
    localparam int CPB = 4;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [7:0] out = '0;
    logic outFlag = 1'b0;
    logic endFlag = 1'b0;
    logic tx, busy, done, overflow;
    logic [4:0] count;
    int total = 0;
    int bad = 0;
    int frames = 0;
    int busy_run = 0;
    int busy_len = 0;
    int idle_run = 0;
    int pos = 0;
    bit in_frame = 0;
    bit gap_check = 0;
    bit gap_armed = 0;
    logic [7:0] rx;
    logic [7:0] exp_q[$];

    cpu_out_uart #(.DATAWIDTH(8), .DEPTH(16), .ADDRESSWIDTH(4), .CLKS_PER_BIT(CPB)) dut (
        .clock(clock),
        .reset(reset),
        .out(out),
        .outFlag(outFlag),
        .endFlag(endFlag),
        .tx(tx),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .count(count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // UART monitor: pos 0 is the first start-bit cycle, bits sampled mid-period
    always @(negedge clock) begin
        if (!reset) begin
            in_frame = 0;
            pos = 0;
            idle_run = 0;
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            else begin
                if (busy_run != 0) busy_len = busy_run;
                busy_run = 0;
            end
            if (!in_frame) begin
                if (tx == 1'b0) begin
                    if (gap_check && gap_armed) check("idle gap", idle_run, 1);
                    in_frame = 1;
                    pos = 0;
                    idle_run = 0;
                end else idle_run++;
            end
            if (in_frame) begin
                if (pos == 2) check("start bit", tx, 0);
                else if (pos >= 6 && pos <= 34 && (pos - 6) % 4 == 0) rx[(pos - 6) / 4] = tx;
                else if (pos == 38) begin
                    check("stop bit", tx, 1);
                    frames++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected frame: got %0h want none", rx);
                    end else check("frame byte", rx, exp_q.pop_front());
                end
                if (pos == 39) begin
                    in_frame = 0;
                    gap_armed = 1;
                end
                pos++;
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit expect_it);
        @(negedge clock);
        out = b;
        outFlag = 1'b1;
        if (expect_it) exp_q.push_back(b);
        @(negedge clock);
        outFlag = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check({name, " drain in time"}, n < 2000, 1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset overflow", overflow, 0);
        check("reset count", count, 0);
        reset = 1'b1;
        @(negedge clock);

        // single byte, strobe held for three cycles
        out = 8'hA5;
        outFlag = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clock);
        check("t1 count after push", count, 1);
        @(negedge clock);
        check("t1 count after pop", count, 0);
        check("t1 busy after pop", busy, 1);
        @(negedge clock);
        outFlag = 1'b0;
        wait_idle("t1");
        repeat (2) @(negedge clock);
        check("t1 busy length", busy_len, 40);
        check("t1 frames", frames, 1);
        check("t1 count idle", count, 0);

        // back-to-back frames
        gap_check = 1;
        gap_armed = 0;
        send(8'h41, 1);
        send(8'h42, 1);
        send(8'h43, 1);
        wait_idle("t2");
        gap_check = 0;
        check("t2 frames", frames, 4);

        // overflow: byte 00 in flight, 01..10 fill, 11 dropped
        send(8'h00, 1);
        for (int i = 1; i <= 16; i++) send(8'(i), 1);
        check("t3 count full", count, 16);
        check("t3 no overflow yet", overflow, 0);
        send(8'h11, 0);
        check("t3 count still full", count, 16);
        check("t3 overflow set", overflow, 1);
        wait_idle("t3");
        repeat (2) @(negedge clock);
        check("t3 overflow sticky", overflow, 1);
        check("t3 frames", frames, 21);

        // reset clears overflow, then push into full FIFO on the IDLE pop cycle
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t4 overflow cleared", overflow, 0);
        check("t4 count cleared", count, 0);
        reset = 1'b1;
        @(negedge clock);
        send(8'hB0, 1);
        for (int i = 0; i < 16; i++) send(8'hC0 + 8'(i), 1);
        check("t4 count full", count, 16);
        begin
            int n = 0;
            while (busy && n < 100) begin
                @(negedge clock);
                n++;
            end
        end
        check("t4 idle cycle found", busy, 0);
        out = 8'hD0;
        outFlag = 1'b1;
        exp_q.push_back(8'hD0);
        @(negedge clock);
        check("t4 count push+pop full", count, 16);
        check("t4 overflow push+pop full", overflow, 0);
        outFlag = 1'b0;
        wait_idle("t4");
        check("t4 frames", frames, 39);

        // end handling
        check("t5 done before end", done, 0);
        send(8'hE1, 1);
        send(8'hE2, 1);
        @(negedge clock);
        endFlag = 1'b1;
        @(negedge clock);
        endFlag = 1'b0;
        check("t5 done while draining", done, 0);
        wait_idle("t5");
        check("t5 done in idle cycle", done, 0);
        @(negedge clock);
        check("t5 done after idle", done, 1);
        out = 8'hF3;
        outFlag = 1'b1;
        exp_q.push_back(8'hF3);
        @(negedge clock);
        check("t5 done lags push", done, 1);
        outFlag = 1'b0;
        @(negedge clock);
        check("t5 done drops", done, 0);
        wait_idle("t5b");
        check("t5b done in idle cycle", done, 0);
        @(negedge clock);
        check("t5b done again", done, 1);
        check("t5 frames", frames, 42);

        // reset during data bit 3 (A5 bit3 = 0)
        @(negedge clock);
        out = 8'hA5;
        outFlag = 1'b1;
        @(negedge clock);
        outFlag = 1'b0;
        begin
            int n = 0;
            while (!busy && n < 10) begin
                @(negedge clock);
                n++;
            end
        end
        repeat (17) @(negedge clock);
        check("t6 tx bit3 before reset", tx, 0);
        #2 reset = 1'b0;
        #1;
        check("t6 tx async reset", tx, 1);
        check("t6 busy async reset", busy, 0);
        check("t6 count async reset", count, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (60) @(negedge clock);
        check("t6 no residual frame", frames, 42);
        check("t6 tx idle", tx, 1);
        check("t6 busy idle", busy, 0);
        check("t6 count idle", count, 0);
        check("scoreboard empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
